// File: rtl/i2c_pkg.sv
// Shared types and parameter defaults for the I2C slave front end.
package i2c_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ADDR = 2'd1,
        BUS_XFER = 2'd2
    } bus_state_t;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int GLITCH_CYCLES_DEF = 2;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one raw I2C pad line.
// A level change is accepted only after it has persisted for
// GLITCH_CYCLES+1 consecutive cycles at the synchroniser output.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered
);

    localparam int CNT_W = $clog2(GLITCH_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GLITCH_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the raw pad level through the synchroniser chain (idle-high bus).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive mismatch cycles and adopt the new level once it has lasted long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtered <= 1'b1;
            cnt      <= '0;
        end else if (synced == filtered) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            filtered <= synced;
            cnt      <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus framing monitor: filters SCL/SDA, detects START, repeated START
// and STOP, and gates the address phase for the downstream address decoder.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
    input  logic FPGA_clk,
    input  logic rst,
    input  logic SCL_in,
    input  logic SDA_in,
    input  logic decoder_done,
    output logic SCL,
    output logic SCL_prev,
    output logic SDA,
    output logic start_det,
    output logic rep_start,
    output logic stop_det,
    output logic addr_rst,
    output logic addr_enable,
    output logic bus_busy
);

    bus_state_t state;
    bus_state_t next_state;
    logic       sda_prev;
    logic       start_cond;
    logic       stop_cond;
    logic       start_nxt;
    logic       rep_nxt;
    logic       stop_nxt;
    logic       addr_rst_nxt;

    i2c_line_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .GLITCH_CYCLES(GLITCH_CYCLES)
    ) u_scl_filter (
        .clk     (FPGA_clk),
        .rst     (rst),
        .raw     (SCL_in),
        .filtered(SCL)
    );

    i2c_line_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .GLITCH_CYCLES(GLITCH_CYCLES)
    ) u_sda_filter (
        .clk     (FPGA_clk),
        .rst     (rst),
        .raw     (SDA_in),
        .filtered(SDA)
    );

    // Requiring SCL high on both sides of the SDA edge means a cycle where
    // SCL and SDA move together never qualifies as START or STOP.
    assign start_cond = SCL && SCL_prev && sda_prev && !SDA;
    assign stop_cond  = SCL && SCL_prev && !sda_prev && SDA;

    // One-cycle history of the filtered lines for edge detection.
    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            SCL_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            SCL_prev <= SCL;
            sda_prev <= SDA;
        end
    end

    // State register together with the registered condition pulses.
    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            state     <= BUS_IDLE;
            start_det <= 1'b0;
            rep_start <= 1'b0;
            stop_det  <= 1'b0;
            addr_rst  <= 1'b0;
        end else begin
            state     <= next_state;
            start_det <= start_nxt;
            rep_start <= rep_nxt;
            stop_det  <= stop_nxt;
            addr_rst  <= addr_rst_nxt;
        end
    end

    // Next-state and pulse decode; STOP outranks START, which outranks decoder_done.
    always_comb begin
        next_state   = state;
        start_nxt    = 1'b0;
        rep_nxt      = 1'b0;
        stop_nxt     = 1'b0;
        addr_rst_nxt = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (stop_cond) begin
                    stop_nxt = 1'b1;
                end else if (start_cond) begin
                    start_nxt    = 1'b1;
                    addr_rst_nxt = 1'b1;
                    next_state   = BUS_ADDR;
                end
            end
            BUS_ADDR, BUS_XFER: begin
                if (stop_cond) begin
                    stop_nxt   = 1'b1;
                    next_state = BUS_IDLE;
                end else if (start_cond) begin
                    rep_nxt      = 1'b1;
                    addr_rst_nxt = 1'b1;
                    next_state   = BUS_ADDR;
                end else if (state == BUS_ADDR && decoder_done) begin
                    next_state = BUS_XFER;
                end
            end
            default: begin
                next_state = BUS_IDLE;
            end
        endcase
    end

    // State-derived outputs; the address phase stays closed while the decoder is being reset.
    always_comb begin
        addr_enable = (state == BUS_ADDR) && !addr_rst;
        bus_busy    = (state != BUS_IDLE);
    end

endmodule
